// File: rtl/alu_ctrl_seq_if.sv
// ALU control sequencer request/response bundle.
// master: producer drives valid_in/alu_op/funct; slave: sequencer drives the rest.
interface alu_ctrl_seq_if #(
    parameter int SEL_W = 4
);
    logic             valid_in;
    logic [2:0]       alu_op;
    logic [5:0]       funct;
    logic             ready_out;
    logic [SEL_W-1:0] select;
    logic             valid_out;
    logic             illegal;
    logic             busy;
    logic             md_start;
    logic             md_done;

    modport master (
        output valid_in, alu_op, funct,
        input  ready_out, select, valid_out, illegal,
        input  busy, md_start, md_done
    );

    modport slave (
        input  valid_in, alu_op, funct,
        output ready_out, select, valid_out, illegal,
        output busy, md_start, md_done
    );
endinterface

// File: rtl/alu_ctrl_seq.sv
// ALU control decode with mult/div occupancy sequencing.
// Ports: clk, rst (async, active-high), bus (alu_ctrl_seq_if.slave).
module alu_ctrl_seq #(
    parameter int SEL_W  = 4,
    parameter int MD_LAT = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_ctrl_seq_if.slave bus
);
    localparam int CNT_W = $clog2(MD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);

    typedef enum logic {
        IDLE,
        MULDIV
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SEL_W-1:0] sel_q;
    logic             ill_q;
    logic             valid_q;
    logic             busy_q;
    logic             ready_q;
    logic             md_start_q;
    logic             md_done_q;

    logic [3:0]       code_d;
    logic [SEL_W-1:0] sel_d;
    logic             ill_d;
    logic             md_d;

    always_comb begin
        code_d = 4'd0;
        ill_d  = 1'b0;
        case (bus.alu_op)
            3'd0: code_d = 4'd0;
            3'd1: code_d = 4'd1;
            3'd3: code_d = 4'd2;
            3'd4: code_d = 4'd3;
            3'd5: code_d = 4'd6;
            3'd6: code_d = 4'd15;
            3'd2: begin
                case (bus.funct)
                    6'h20, 6'h21: code_d = 4'd0;
                    6'h22, 6'h23: code_d = 4'd1;
                    6'h24:        code_d = 4'd2;
                    6'h25:        code_d = 4'd3;
                    6'h00:        code_d = 4'd4;
                    6'h02:        code_d = 4'd5;
                    6'h2A:        code_d = 4'd6;
                    6'h26:        code_d = 4'd7;
                    6'h27:        code_d = 4'd8;
                    6'h03:        code_d = 4'd9;
                    6'h2B:        code_d = 4'd10;
                    6'h18:        code_d = 4'd11;
                    6'h19:        code_d = 4'd12;
                    6'h1A:        code_d = 4'd13;
                    6'h1B:        code_d = 4'd14;
                    default:      ill_d  = 1'b1;
                endcase
            end
            default: ill_d = 1'b1;
        endcase
    end

    assign sel_d = SEL_W'(code_d);
    // Codes 11..14 are mult/div; lui (15) is single-cycle.
    assign md_d  = !ill_d && (code_d >= 4'd11) && (code_d <= 4'd14);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_q      <= '0;
            ill_q      <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            md_start_q <= 1'b0;
            md_done_q  <= 1'b0;
        end else begin
            valid_q    <= 1'b0;
            md_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.valid_in) begin
                        valid_q <= 1'b1;
                        sel_q   <= sel_d;
                        ill_q   <= ill_d;
                        if (md_d) begin
                            state_q    <= MULDIV;
                            cnt_q      <= CNT_LOAD;
                            busy_q     <= 1'b1;
                            ready_q    <= 1'b0;
                            md_start_q <= 1'b1;
                        end
                    end
                end
                MULDIV: begin
                    // md_done is registered off cnt==1, so it lands in
                    // the last busy cycle and busy spans MD_LAT cycles.
                    if (md_done_q) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        busy_q    <= 1'b0;
                        ready_q   <= 1'b1;
                        md_done_q <= 1'b0;
                    end else begin
                        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                        md_done_q <= (cnt_q == CNT_W'(1));
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready_out = ready_q;
    assign bus.select    = sel_q;
    assign bus.valid_out = valid_q;
    assign bus.illegal   = ill_q;
    assign bus.busy      = busy_q;
    assign bus.md_start  = md_start_q;
    assign bus.md_done   = md_done_q;
endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameter SEL_W, default 4: width of select output; SHALL be >= 4.
REQ-002 Parameter MD_LAT, default 32: cycles a mult/div operation occupies the block; SHALL be >= 2.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 valid_in  input  1  decode request present this cycle.
REQ-006 alu_op  input  3  main-control ALU operation class.
REQ-007 funct  input  6  instruction funct field; used only when alu_op = 2.
REQ-008 ready_out  output  1  block accepts a request this cycle.
REQ-009 select  output  SEL_W  registered ALU operation code.
REQ-010 valid_out  output  1  one-cycle pulse: select/illegal updated this cycle.
REQ-011 illegal  output  1  accepted request had an unsupported encoding; qualified by valid_out.
REQ-012 busy  output  1  multi-cycle mult/div in progress.
REQ-013 md_start  output  1  one-cycle pulse launching the mult/div unit.
REQ-014 md_done  output  1  one-cycle pulse on the final mult/div cycle.

Function
REQ-015 Request accepted when valid_in=1 and ready_out=1; no other request changes state.
REQ-016 select, illegal and valid_out SHALL update on the clock edge after acceptance (1-cycle latency).
REQ-017 alu_op map: 0 -> 0 (add), 1 -> 1 (sub), 3 -> 2 (and), 4 -> 3 (or), 5 -> 6 (slt), 6 -> 15 (lui), 2 -> funct table, 7 -> illegal.
REQ-018 funct table (hex -> select): 20,21 -> 0; 22,23 -> 1; 24 -> 2; 25 -> 3; 00 -> 4; 02 -> 5; 2A -> 6; 26 -> 7; 27 -> 8; 03 -> 9; 2B -> 10; 18 -> 11; 19 -> 12; 1A -> 13; 1B -> 14.
REQ-019 Any other funct with alu_op=2 SHALL be illegal.
REQ-020 Illegal request: select <= 0, illegal <= 1, valid_out pulses, no state change beyond that.
REQ-021 Legal request: illegal <= 0.
REQ-022 select values zero-extended to SEL_W.
REQ-023 select and illegal SHALL hold their last values when no request is accepted.
REQ-024 FSM states: IDLE, MULDIV.
REQ-025 IDLE: ready_out=1, busy=0.
REQ-026 IDLE -> MULDIV on acceptance of select 11-14.
REQ-027 On that same edge: md_start pulses with valid_out, and counter loads MD_LAT-1.
REQ-028 MULDIV: ready_out=0, busy=1, counter decrements each cycle.
REQ-029 MULDIV, counter=1: md_done=1 that cycle; next edge -> IDLE.
REQ-030 Result: busy high exactly MD_LAT cycles; ready_out returns MD_LAT cycles after md_start.
REQ-031 valid_in asserted while ready_out=0 SHALL be ignored; the producer holds the request until accepted.
REQ-032 Back-to-back legal non-mult/div requests SHALL be accepted every cycle, with valid_out high every cycle.
REQ-033 Mult/div request accepted the cycle after md_done SHALL start a new MULDIV with no gap cycle.

Reset
REQ-034 rst=1 asynchronously forces IDLE, counter=0, select=0, illegal=0, valid_out=0, busy=0, md_start=0, md_done=0, ready_out=1.
REQ-035 Reset asserted during MULDIV SHALL abort the operation with no md_done pulse.
REQ-036 First acceptance is possible on the first posedge after rst deasserts.

Verification
REQ-037 Sweep alu_op=2 with funct 20, 22, 24, 25, 00, 02, 2A -> select 0, 1, 2, 3, 4, 5, 6, each one cycle later, with valid_out=1 and illegal=0.
REQ-038 alu_op=2, funct=3F -> select=0, illegal=1, valid_out=1; then alu_op=7 -> illegal=1.
REQ-039 alu_op=2, funct=1A, MD_LAT=4 -> select=13 with md_start; busy=1 for 4 cycles; md_done on the 4th cycle; ready_out=1 the next cycle.
REQ-040 valid_in held with alu_op=0 during MULDIV -> no valid_out until ready_out returns, then select=0 one cycle later.
REQ-041 rst pulsed mid-MULDIV -> outputs immediately at reset values, no md_done; alu_op=6 next -> select=15.
